// File: rtl/riscv_pkg.sv
// Shared definitions for the core data path: bus widths, store-buffer depth and
// the buffered-store entry layout.
package riscv_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-3:0] word_addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    localparam int SB_ENTRY_W = $bits(sb_entry_t);
endpackage

// File: rtl/sb_match.sv
// Store-to-load forwarding lookup: finds the youngest valid buffered store whose
// word address matches the load address.
module sb_match
    import riscv_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic [DEPTH*SB_ENTRY_W-1:0] entries_i,
    input  logic [$clog2(DEPTH)-1:0]    head_i,
    input  logic [ADDR_W-3:0]           word_addr_i,
    output logic                        hit_o,
    output logic [DATA_W-1:0]           data_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx_s;
    sb_entry_t     ent_s;

    // Walk oldest to youngest from head so the last match seen is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        data_o = {DATA_W{1'b0}};
        idx_s  = head_i;
        ent_s  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_i + PW'(i);
            ent_s = entries_i[int'(idx_s)*SB_ENTRY_W +: SB_ENTRY_W];
            if (ent_s.valid && (ent_s.word_addr == word_addr_i)) begin
                hit_o  = 1'b1;
                data_o = ent_s.data;
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end
endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between the core data port and data memory. Define
// STORE_BUF_FWD_EN to forward buffered data to matching loads; otherwise loads wait for empty.
module store_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              stall_o,
    output logic              empty_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    sb_entry_t     entries_q [DEPTH];
    sb_entry_t     entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    logic              full_s, store_s, load_s, load_hit_s, load_wait_s;
    logic              load_miss_s, mem_load_s, drain_s, enq_s, stall_s;
    logic [DATA_W-1:0] fwd_data_s;
    sb_entry_t         head_ent_s;

    assign head_ent_s = entries_q[head_q];
    assign full_s     = (count_q == CNT_FULL);
    assign store_s    = ce_i & we_i;
    assign load_s     = ce_i & ~we_i;

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH*SB_ENTRY_W-1:0] entries_flat_s;
    logic                        hit_s;

    // Flatten the entry array for the match unit.
    always_comb begin
        entries_flat_s = {(DEPTH*SB_ENTRY_W){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entries_flat_s[i*SB_ENTRY_W +: SB_ENTRY_W] = entries_q[i];
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_sb_match (
        .entries_i   (entries_flat_s),
        .head_i      (head_q),
        .word_addr_i (addr_i[ADDR_W-1:2]),
        .hit_o       (hit_s),
        .data_o      (fwd_data_s)
    );

    assign load_hit_s  = load_s & hit_s;
    assign load_wait_s = 1'b0;
`else
    assign fwd_data_s  = {DATA_W{1'b0}};
    assign load_hit_s  = 1'b0;
    assign load_wait_s = load_s & (count_q != CNT_ZERO);
`endif

    // A load miss owns the memory port unless the buffer is full, in which case the drain wins.
    assign load_miss_s = load_s & ~load_hit_s & ~load_wait_s;
    assign mem_load_s  = load_miss_s & ~full_s;
    assign drain_s     = (count_q != CNT_ZERO) & head_ent_s.valid & ~mem_load_s;
    assign enq_s       = store_s & ~full_s;
    assign stall_s     = (store_s & full_s) | (load_miss_s & full_s) | load_wait_s;
    assign empty_o     = rst | (count_q == CNT_ZERO);

    // Next-state for FIFO pointers, occupancy and entries.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        if (enq_s) begin
            entries_d[tail_q] = '{valid: 1'b1, word_addr: addr_i[ADDR_W-1:2], data: data_i};
            tail_d            = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (drain_s) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        count_d = count_q + (PW+1)'(enq_s) - (PW+1)'(drain_s);
    end

    // State registers; reset discards every buffered store.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= CNT_ZERO;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // Core and memory port drive; everything is quiet while reset is held.
    always_comb begin
        stall_o    = 1'b0;
        mem_ce_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = {ADDR_W{1'b0}};
        mem_data_o = {DATA_W{1'b0}};
        data_o     = {DATA_W{1'b0}};
        if (rst) begin
            stall_o = 1'b0;
        end else begin
            stall_o  = stall_s;
            mem_ce_o = mem_load_s | drain_s;
            mem_we_o = drain_s;
            if (mem_load_s) begin
                mem_addr_o = addr_i;
                data_o     = mem_data_i;
            end else if (drain_s) begin
                mem_addr_o = {head_ent_s.word_addr, 2'b00};
                mem_data_o = head_ent_s.data;
                data_o     = load_hit_s ? fwd_data_s : {DATA_W{1'b0}};
            end else begin
                data_o = load_hit_s ? fwd_data_s : {DATA_W{1'b0}};
            end
        end
    end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered stores; power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ce_i  input  1  core data-port request valid.
REQ-005 we_i  input  1  request is a store (1) or a load (0).
REQ-006 addr_i  input  32  core byte address; word-aligned, bits [1:0] ignored.
REQ-007 data_i  input  32  store data from core.
REQ-008 data_o  output  32  load data to core.
REQ-009 stall_o  output  1  request not accepted this cycle; core holds request.
REQ-010 empty_o  output  1  no buffered stores; used by core for fence.
REQ-011 mem_ce_o  output  1  data memory enable.
REQ-012 mem_we_o  output  1  data memory write.
REQ-013 mem_addr_o  output  32  data memory address.
REQ-014 mem_data_o  output  32  data memory write data.
REQ-015 mem_data_i  input  32  data memory read data, combinational in same cycle.

Function
REQ-016 Block SHALL sit between core data port and data_mem, holding up to DEPTH word stores in FIFO order.
REQ-017 Store (ce_i & we_i) with count<DEPTH SHALL enqueue {addr_i[31:2], data_i} at tail on the clock edge; stall_o=0.
REQ-018 Store with count==DEPTH SHALL assert stall_o and not enqueue; head still drains that cycle.
REQ-019 Head/tail pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH, never over/underflow.
REQ-020 Drain: when count>0 and memory port not claimed by a load, block SHALL drive mem_ce_o=1, mem_we_o=1, head addr/data; head retires at edge.
REQ-021 Enqueued store SHALL be drainable no earlier than the following cycle (min latency 1).
REQ-022 Same-cycle enqueue and drain SHALL both take effect when count<DEPTH; count unchanged.
REQ-023 Load (ce_i & ~we_i) matching a buffered entry on addr[31:2] SHALL return data of youngest matching entry combinationally; stall_o=0; drain proceeds.
REQ-024 Load miss with count<DEPTH SHALL claim memory port: mem_ce_o=1, mem_we_o=0, mem_addr_o=addr_i, data_o=mem_data_i; drain deferred.
REQ-025 Load miss with count==DEPTH SHALL assert stall_o; drain takes port, load retried next cycle.
REQ-026 ce_i=0: data_o=0, stall_o=0; drain continues.
REQ-027 empty_o SHALL equal (count==0), registered-state derived, no combinational path from inputs.
REQ-028 mem_ce_o=0 and mem_we_o=0 when no load miss and buffer empty.

Reset
REQ-029 rst sampled at rising edge SHALL clear head, tail, count and all entry-valid bits; buffered stores discarded.
REQ-030 While rst=1: mem_ce_o=0, mem_we_o=0, stall_o=0, data_o=0, empty_o=1; reset mid-drain aborts without write.

Configuration
REQ-031 Macro STORE_BUF_FWD_EN defined: forwarding per REQ-023.
REQ-032 Macro STORE_BUF_FWD_EN undefined: any load with count>0 SHALL stall until buffer empty, then read memory per REQ-024; no address comparators synthesized.

Structure
REQ-033 Shared package riscv_pkg SHALL hold DATA_W=32, ADDR_W=32, SB_DEPTH default and entry struct {valid, word_addr[29:0], data[31:0]}.
REQ-034 Forwarding compare SHALL live in sub-module sb_match (entries, head, addr in -> hit, youngest data), instantiated only under STORE_BUF_FWD_EN.

Verification
REQ-035 Store 0x100<-0xDEADBEEF, then idle -> next cycle mem_we_o=1, mem_addr_o=0x100, mem_data_o=0xDEADBEEF; empty_o=1 after.
REQ-036 Four back-to-back stores then fifth while load misses block port -> fifth sees stall_o=1 until a drain; memory receives writes in issue order.
REQ-037 Store 0x200<-0x11, store 0x200<-0x22, load 0x200 same cycle as first drain -> data_o=0x22 (FWD_EN) or stall until empty then 0x22 (no FWD_EN).
REQ-038 Load 0x300 miss with mem holding 0x5A5A5A5A, buffer count=2 -> data_o=0x5A5A5A5A, mem_we_o=0, count still 2.
REQ-039 Fill buffer to 3, assert rst one cycle -> no further mem_we_o pulses, empty_o=1, count=0.
REQ-040 Pointer wrap: 10 stores to 0x0,0x4..0x24 with interleaved drains -> data_mem verify contents match in order, no lost or duplicated write.
